uart_tx_scheduler: RTL
======================

# uart_tx_scheduler

Round-robin scheduler that shares one UART byte transmitter between `NUM_REQ` requesters. It accepts bytes over per-requester valid/ready ports and drives the transmitter's active-low start strobe and data. It tracks the transmitter's busy flag and enforces an inter-frame gap. Multi-byte messages keep the grant until their last byte.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `GAP_CLOCKS`, 16: idle clocks inserted after the transmitter drops busy, before the next strobe; 0 means no gap.
- `ACK_TIMEOUT`, 8: clocks allowed between the strobe and the transmitter's busy rising.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in NUM_REQ: per-requester byte available.
- `req_data` in 8*NUM_REQ: requester i's byte is on bits [8i+7:8i].
- `req_last` in NUM_REQ: byte is the last of a message; releases the lock.
- `req_ready` out NUM_REQ: one-hot or zero, combinational; a transfer occurs when `req_valid[i] & req_ready[i]`.
- `tx_data` out 8: byte to the transmitter; registered.
- `tx_data_en` out 1: active-low start strobe to the transmitter; registered.
- `tx_busy` in 1: transmitter busy flag.
- `grant_id` out max(1,$clog2(NUM_REQ)): index of the last accepted requester.
- `sched_busy` out 1: high when state != S_IDLE or the lock is held.
- `err_timeout` out 1: one-cycle pulse when a strobe was not acknowledged.

## Operation
- FSM states: S_IDLE, S_START, S_WAIT_ACK, S_WAIT_DONE, S_GAP.
- **S_IDLE, unlocked**
  - Round-robin pick among `req_valid`, searching from `last+1` upward with wrap.
  - `req_ready` is asserted for the winner only.
  - On transfer: capture the byte into `tx_data`, set `grant_id`/`last` = winner, set `locked` = ~`req_last[winner]`, go to S_START.
- **S_IDLE, locked**
  - Only `req_ready[grant_id]` may assert.
  - Other requesters wait, even if valid, until the locked requester sends its last byte.
- **S_START**
  - `tx_data_en` = 0 for exactly this one cycle; `tx_data` is stable.
  - Next state S_WAIT_ACK.
- **S_WAIT_ACK**
  - `tx_busy` = 1: go to S_WAIT_DONE.
  - Otherwise count cycles. After ACK_TIMEOUT cycles without busy: pulse `err_timeout`, drop the byte, clear `locked`, go to S_IDLE.
- **S_WAIT_DONE**
  - Wait for `tx_busy` = 0, then go to S_GAP. The gap counter is loaded with GAP_CLOCKS.
- **S_GAP**
  - Count down; reach S_IDLE when the count hits 0.
  - With GAP_CLOCKS = 0, go straight to S_IDLE.
- `tx_data_en` is 1 in every state except S_START. A held-low strobe would retrigger the transmitter and is forbidden.
- Counters are `$clog2(max(GAP_CLOCKS, ACK_TIMEOUT)+1)` bits wide, saturating, with no wrap.
- Simultaneous `req_valid` on all lines: strict rotation, so each requester is served once per NUM_REQ unlocked grants.
- A `req_valid` deassertion while `req_ready` is high is legal; no transfer occurs.

## Timing
- Reset values: `tx_data_en` = 1, `tx_data` = 0x00, `req_ready` = 0, `grant_id` = 0, `sched_busy` = 0, `err_timeout` = 0, state S_IDLE, `locked` = 0, `last` = NUM_REQ-1 (requester 0 wins first).
- `rst` asserted mid-transfer forces the reset state at once; the in-flight byte is abandoned.
- Transfer at edge E0, then strobe low during cycle E0..E1. The transmitter latches at E1, and busy is expected from E1 onward.
- Minimum byte-to-byte spacing per requester: transmitter frame time + GAP_CLOCKS + 3 clk.
- `req_ready` is never asserted outside S_IDLE. At most one transfer occurs per byte frame.

## Structure
- Package `uart_pkg`: `sched_state_t` enum, and the default constants for GAP and timeout.
- Sub-module `rr_arbiter`: parameterized NUM_REQ, with `req`, `mask_en`/`mask_id` for the lock, `last`, and one-hot `gnt` output. It is combinational.
- The FSM, counters and registers live in `uart_tx_scheduler`.

## Test plan
1. **Single byte:** reset, then requester 2 sends 0xA5 with `req_last` = 1. Required:
   - `req_ready` = 0100 for one cycle.
   - One cycle later, `tx_data_en` = 0 for one cycle with `tx_data` = 0xA5.
   - `grant_id` = 2.
2. **Round-robin:** all four requesters valid with single bytes 0x10..0x13. Grants are in order 0, 1, 2, 3; after the next refill, order resumes at 0.
3. **Lock:** requester 1 sends 0x01, 0x02, 0x03 (last on 0x03) while requester 0 is continuously valid. Required:
   - The three bytes from requester 1 are transmitted back-to-back.
   - Requester 0 is served only after 0x03.
   - Requester 1 may stall between bytes; the lock is held.
4. **Timeout:** the transmitter model never raises busy, ACK_TIMEOUT = 8. Required:
   - `err_timeout` pulses exactly 8 cycles after S_WAIT_ACK is entered.
   - The FSM returns to idle and the lock is cleared.
5. **Gap:** GAP_CLOCKS = 16. Required: exactly 16 cycles with `tx_data_en` = 1 between busy falling and the S_IDLE re-entry; the next strobe follows 2 cycles later.
6. **Reset mid-frame:** assert `rst` during S_WAIT_DONE. Required: all outputs take their reset values asynchronously, and requester 0 wins first after release.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
// Holds the FSM state type and width helpers used by the scheduler slice.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_GAP
    } sched_state_t;

    localparam int GAP_CLOCKS_DEF  = 16;
    localparam int ACK_TIMEOUT_DEF = 8;

    function automatic int id_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int gap, input int ack);
        int m;
        m = (gap > ack) ? gap : ack;
        return (m > 0) ? $clog2(m + 1) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester handshake and transmitter bundle for the UART scheduler.
// slave is the scheduler side; master is the requesters plus transmitter.
interface uart_tx_scheduler_if #(
    parameter int NUM_REQ = 4
);
    localparam int IDW = uart_pkg::id_w(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           tx_data;
    logic                 tx_data_en;
    logic                 tx_busy;
    logic [IDW-1:0]       grant_id;
    logic                 sched_busy;
    logic                 err_timeout;

    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_data, tx_data_en, grant_id,
        output sched_busy, err_timeout
    );

    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_data, tx_data_en, grant_id,
        input  sched_busy, err_timeout
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter with an optional single-requester lock.
// Searches upward from last+1 with wrap; a lock restricts the grant to mask_id.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]          req,
    input  logic                        mask_en,
    input  logic [id_w(NUM_REQ)-1:0]    mask_id,
    input  logic [id_w(NUM_REQ)-1:0]    last,
    output logic [NUM_REQ-1:0]          gnt
);
    localparam int IDW = id_w(NUM_REQ);

    logic [IDW-1:0] idx;
    logic           found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        if (mask_en) begin
            gnt[mask_id] = req[mask_id];
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                idx = IDW'((int'(last) + k) % NUM_REQ);
                if (!found && req[idx]) begin
                    gnt[idx] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART byte transmitter between NUM_REQ requesters, round robin,
// with message locking, busy tracking, ack timeout and an inter-frame gap.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int GAP_CLOCKS  = GAP_CLOCKS_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_scheduler_if.slave bus
);
    localparam int IDW = id_w(NUM_REQ);
    localparam int CW  = cnt_w(GAP_CLOCKS, ACK_TIMEOUT);

    sched_state_t       state;
    logic               locked;
    logic [IDW-1:0]     last;
    logic [IDW-1:0]     grant_id;
    logic [CW-1:0]      cnt;
    logic [7:0]         tx_data;
    logic               tx_data_en;
    logic               err_timeout;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] ready;
    logic [IDW-1:0]     win_id;
    logic [7:0]         win_data;
    logic               win_last;
    logic               xfer;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .req    (bus.req_valid),
        .mask_en(locked),
        .mask_id(grant_id),
        .last   (last),
        .gnt    (gnt)
    );

    always_comb begin
        win_id   = '0;
        win_data = '0;
        win_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                win_id   = IDW'(i);
                win_data = bus.req_data[8*i +: 8];
                win_last = bus.req_last[i];
            end
        end
    end

    // Ready is only offered while idle, and never while reset is held.
    assign ready = (state == S_IDLE && !rst) ? gnt : '0;
    assign xfer  = |(ready & bus.req_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            locked      <= 1'b0;
            last        <= IDW'(NUM_REQ - 1);
            grant_id    <= '0;
            cnt         <= '0;
            tx_data     <= 8'h00;
            tx_data_en  <= 1'b1;
            err_timeout <= 1'b0;
        end else begin
            tx_data_en  <= 1'b1;
            err_timeout <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (xfer) begin
                        tx_data    <= win_data;
                        grant_id   <= win_id;
                        last       <= win_id;
                        locked     <= ~win_last;
                        tx_data_en <= 1'b0;
                        state      <= S_START;
                    end
                end
                S_START: begin
                    cnt   <= '0;
                    state <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (bus.tx_busy) begin
                        state <= S_WAIT_DONE;
                    end else if (cnt >= CW'(ACK_TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        locked      <= 1'b0;
                        state       <= S_IDLE;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        if (GAP_CLOCKS == 0) begin
                            state <= S_IDLE;
                        end else begin
                            cnt   <= CW'(GAP_CLOCKS);
                            state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    // Loaded on the busy-low edge, so the gap spans GAP_CLOCKS cycles.
                    if (cnt <= CW'(1)) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready   = ready;
    assign bus.tx_data     = tx_data;
    assign bus.tx_data_en  = tx_data_en;
    assign bus.grant_id    = grant_id;
    assign bus.sched_busy  = (state != S_IDLE) || locked;
    assign bus.err_timeout = err_timeout;

endmodule
